// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared constants and types for the instruction/data bus arbiter.
//   RegBus      - width of the address and data words
//   ZeroWord    - all-zero word used as the reset value of data registers
//   RstEnable   - active level of the reset input (active low)
//   arb_state_t - arbiter FSM state encoding (ARB_IDLE .. ARB_DRAIN)
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int           RegBus    = 32;
    localparam logic [31:0]  ZeroWord  = 32'h0000_0000;
    localparam logic         RstEnable = 1'b0;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_IF_BUSY  = 3'd1,
        ARB_MEM_BUSY = 3'd2,
        ARB_RESP     = 3'd3,
        ARB_DRAIN    = 3'd4
    } arb_state_t;

    // True while a bus transaction is outstanding and owned by a live request.
    function automatic logic arb_is_busy(input arb_state_t st);
        return (st == ARB_IF_BUSY) || (st == ARB_MEM_BUSY);
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares one single-ported memory bus between the instruction-fetch (IF) and
// load/store (MEM) stages. MEM wins on simultaneous requests. Each transaction
// is captured into registered bus_* outputs, held until bus_ack, and followed
// by a one-cycle RESP state in which the owner's stall request is released.
// A flush during an outstanding transaction lets it finish on the bus (DRAIN)
// while discarding the returned data.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active low
//   if_req        fetch request            if_addr   fetch address
//   if_rdata      fetched instruction      if_stallreq  stall IF
//   mem_req       load/store request       mem_we    write enable
//   mem_sel       byte enables             mem_addr  address
//   mem_wdata     store data               mem_rdata load data
//   mem_stallreq  stall MEM
//   flush         pipeline flush
//   bus_req/we/sel/addr/wdata  registered bus request fields
//   bus_ack       one-cycle completion     bus_rdata read data (valid on ack)
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [RegBus-1:0] if_addr,
    output logic [RegBus-1:0] if_rdata,
    output logic              if_stallreq,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [RegBus-1:0] mem_addr,
    input  logic [RegBus-1:0] mem_wdata,
    output logic [RegBus-1:0] mem_rdata,
    output logic              mem_stallreq,

    input  logic              flush,

    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [RegBus-1:0] bus_addr,
    output logic [RegBus-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [RegBus-1:0] bus_rdata
);

    arb_state_t state_reg;
    // Remembers which side owns the current/just-finished transaction so that
    // RESP releases only that side's stall.
    logic       owner_if_reg;

    logic resp_if;
    logic resp_mem;

    assign resp_if  = (state_reg == ARB_RESP) &&  owner_if_reg;
    assign resp_mem = (state_reg == ARB_RESP) && !owner_if_reg;

    // Stalls are combinational so the requesting stage freezes in the very
    // cycle it asks for the bus; they are forced low while reset is applied.
    always_comb begin
        if_stallreq  = 1'b0;
        mem_stallreq = 1'b0;
        if (rst != RstEnable) begin
            if_stallreq  = if_req  && !resp_if  && !flush;
            mem_stallreq = mem_req && !resp_mem && !flush;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_reg    <= ARB_IDLE;
            owner_if_reg <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_sel      <= 4'b0000;
            bus_addr     <= ZeroWord;
            bus_wdata    <= ZeroWord;
            if_rdata     <= ZeroWord;
            mem_rdata    <= ZeroWord;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    // A flush in IDLE suppresses capture of this cycle's
                    // requests; spurious acks are ignored here.
                    if (!flush) begin
                        if (mem_req) begin
                            bus_req      <= 1'b1;
                            bus_we       <= mem_we;
                            bus_sel      <= mem_sel;
                            bus_addr     <= mem_addr;
                            bus_wdata    <= mem_wdata;
                            owner_if_reg <= 1'b0;
                            state_reg    <= ARB_MEM_BUSY;
                        end else if (if_req) begin
                            bus_req      <= 1'b1;
                            bus_we       <= 1'b0;
                            bus_sel      <= 4'b1111;
                            bus_addr     <= if_addr;
                            bus_wdata    <= ZeroWord;
                            owner_if_reg <= 1'b1;
                            state_reg    <= ARB_IF_BUSY;
                        end
                    end
                end

                ARB_IF_BUSY, ARB_MEM_BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (flush) begin
                            // Completed but flushed in the same cycle: drop data.
                            state_reg <= ARB_IDLE;
                        end else begin
                            if (arb_is_busy(state_reg) && owner_if_reg) begin
                                if_rdata <= bus_rdata;
                            end else if (!bus_we) begin
                                // Stores leave the load-data register alone.
                                mem_rdata <= bus_rdata;
                            end
                            state_reg <= ARB_RESP;
                        end
                    end else if (flush) begin
                        // Bus cycle must still complete (stores especially).
                        state_reg <= ARB_DRAIN;
                    end
                end

                ARB_RESP: begin
                    state_reg <= ARB_IDLE;
                end

                ARB_DRAIN: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        state_reg <= ARB_IDLE;
                    end
                end

                default: begin
                    bus_req   <= 1'b0;
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
